// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port byte-enabled block RAM:
// FSM state encoding, read-during-write mode codes and a width helper.
package bram_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bram_dp_if.sv
// Bus bundle for both RAM ports plus the BUSY/COLL status lines.
// The master drives requests; the slave (the RAM) returns data and status.
interface bram_dp_if #(
  parameter int DATA_W = 32
);
  localparam int BYTE_W = DATA_W / 8;

  logic              EN0;
  logic [BYTE_W-1:0] WE0;
  logic [31:0]       A0;
  logic [DATA_W-1:0] Di0;
  logic [DATA_W-1:0] Do0;
  logic              VLD0;

  logic              EN1;
  logic [BYTE_W-1:0] WE1;
  logic [31:0]       A1;
  logic [DATA_W-1:0] Di1;
  logic [DATA_W-1:0] Do1;
  logic              VLD1;

  logic              BUSY;
  logic              COLL;

  modport master (
    output EN0, WE0, A0, Di0, EN1, WE1, A1, Di1,
    input  Do0, VLD0, Do1, VLD1, BUSY, COLL
  );

  modport slave (
    input  EN0, WE0, A0, Di0, EN1, WE1, A1, Di1,
    output Do0, VLD0, Do1, VLD1, BUSY, COLL
  );

endinterface

// File: rtl/bram_dp_port.sv
// One RAM port: word-index decode, lane merge for write-first reads and the
// output pipeline (stage 1 always, stage 2 when OUT_REG is set).
module bram_dp_port
  import bram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [31:0]           a,
  input  logic [DATA_W-1:0]     di,
  input  logic [DATA_W-1:0]     rword,
  output logic [ADDR_W-1:0]     idx,
  output logic [DATA_W/8-1:0]   wmask,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvld
);

  localparam int BYTE_W = DATA_W / 8;
  localparam int AL     = clog2(BYTE_W);

  logic              acc;
  logic              unused_abits;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] s1_data;
  logic              s1_vld;

  // Upper address bits alias onto the same word, so they are simply dropped.
  assign idx          = a[ADDR_W+AL-1:AL];
  assign unused_abits = ^a;
  assign acc          = en & ready & ~rst;
  assign wmask        = we & {BYTE_W{acc}};

  always_comb begin
    merged = rword;
    for (int i = 0; i < BYTE_W; i++) begin
      if (we[i]) merged[8*i +: 8] = di[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else if (acc) begin
      s1_data <= (RDW_MODE == RDW_WRITE_FIRST) ? merged : rword;
      s1_vld  <= 1'b1;
    end else begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] s2_data;
      logic              s2_vld;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else begin
          s2_data <= s1_data;
          s2_vld  <= s1_vld;
        end
      end

      assign rdata = s2_data;
      assign rvld  = s2_vld;
    end else begin : g_no_reg
      assign rdata = s1_data;
      assign rvld  = s1_vld;
    end
  endgenerate

endmodule

// File: rtl/bram_dp.sv
// True dual-port byte-enabled RAM with a post-reset zero-fill sequencer and
// same-word write collision flag; port 1 wins lanes written by both ports.
module bram_dp
  import bram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int OUT_REG      = 0,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic      CLK,
  input  logic      RST,
  bram_dp_if.slave  bus
);

  localparam int BYTE_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              busy;
  logic              coll;
  logic              ready;
  logic [ADDR_W-1:0] idx0, idx1;
  logic [BYTE_W-1:0] wmask0, wmask1;
  logic [DATA_W-1:0] rword0, rword1;

  assign ready    = (state == ST_READY);
  assign rword0   = mem[idx0];
  assign rword1   = mem[idx1];
  assign bus.BUSY = busy;
  assign bus.COLL = coll;

  // BUSY stays high through ST_RESET and every clear cycle, dropping on the
  // edge that writes the last word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_RESET;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_RESET: begin
          if (CLEAR_ON_RST != 0) begin
            state <= ST_CLEAR;
          end else begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + (ADDR_W+1)'(1);
          if (cnt == (ADDR_W+1)'(DEPTH-1)) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Port 1 lane writes are issued after port 0, so overlapping lanes keep port 1 data.
  always_ff @(posedge CLK) begin
    if (!RST && state == ST_CLEAR) mem[cnt[ADDR_W-1:0]] <= '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (wmask0[i]) mem[idx0][8*i +: 8] <= bus.Di0[8*i +: 8];
      if (wmask1[i]) mem[idx1][8*i +: 8] <= bus.Di1[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) coll <= 1'b0;
    else     coll <= (idx0 == idx1) && (|(wmask0 & wmask1));
  end

  bram_dp_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .OUT_REG (OUT_REG),
    .RDW_MODE(RDW_MODE)
  ) u_port0 (
    .clk  (CLK),
    .rst  (RST),
    .ready(ready),
    .en   (bus.EN0),
    .we   (bus.WE0),
    .a    (bus.A0),
    .di   (bus.Di0),
    .rword(rword0),
    .idx  (idx0),
    .wmask(wmask0),
    .rdata(bus.Do0),
    .rvld (bus.VLD0)
  );

  bram_dp_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .OUT_REG (OUT_REG),
    .RDW_MODE(RDW_MODE)
  ) u_port1 (
    .clk  (CLK),
    .rst  (RST),
    .ready(ready),
    .en   (bus.EN1),
    .we   (bus.WE1),
    .a    (bus.A1),
    .di   (bus.Di1),
    .rword(rword1),
    .idx  (idx1),
    .wmask(wmask1),
    .rdata(bus.Do1),
    .rvld (bus.VLD1)
  );

endmodule

// File: tb/tb_bram_dp.sv
// Bench for bram_dp: three instances (read-first, write-first, output-registered)
// share one stimulus stream and are compared every cycle against a memory model.
module tb_bram_dp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1;
  logic [3:0]  we0, we1;
  logic [31:0] a0, a1, di0, di1;

  logic [31:0] do0_o [3];
  logic [31:0] do1_o [3];
  logic        vld0_o [3];
  logic        vld1_o [3];
  logic        busy_o [3];
  logic        coll_o [3];

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: plain memory plus expected outputs per instance and port.
  logic [31:0] refMem [DEPTH];
  logic [31:0] expDo  [3][2];
  logic        expVld [3][2];
  logic        expBusy;
  logic        expColl;
  int          remBusy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bram_dp_if #(.DATA_W(DATA_W)) bus ();

    assign bus.EN0 = en0;
    assign bus.WE0 = we0;
    assign bus.A0  = a0;
    assign bus.Di0 = di0;
    assign bus.EN1 = en1;
    assign bus.WE1 = we1;
    assign bus.A1  = a1;
    assign bus.Di1 = di1;

    assign do0_o[g]  = bus.Do0;
    assign do1_o[g]  = bus.Do1;
    assign vld0_o[g] = bus.VLD0;
    assign vld1_o[g] = bus.VLD1;
    assign busy_o[g] = bus.BUSY;
    assign coll_o[g] = bus.COLL;

    bram_dp #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .OUT_REG     ((g == 2) ? 1 : 0),
      .RDW_MODE    ((g == 1) ? 1 : 0),
      .CLEAR_ON_RST(1)
    ) u_dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic modelStep();
    logic [3:0]  idx [2];
    logic [31:0] oldW [2];
    logic [31:0] newW;
    logic        ens [2];
    logic [3:0]  wes [2];
    logic [31:0] dis [2];
    logic        readyNow;
    ens = '{en0, en1};
    wes = '{we0, we1};
    dis = '{di0, di1};
    idx = '{a0[5:2], a1[5:2]};
    expDo[2]  = '{expDo[0][0], expDo[0][1]};
    expVld[2] = '{expVld[0][0], expVld[0][1]};
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        expDo[g]  = '{32'h0, 32'h0};
        expVld[g] = '{1'b0, 1'b0};
      end
      expBusy = 1'b1;
      expColl = 1'b0;
      remBusy = DEPTH;
      for (int w = 0; w < DEPTH; w++) refMem[w] = 32'h0;
    end else begin
      readyNow = !expBusy;
      for (int p = 0; p < 2; p++) begin
        oldW[p] = refMem[idx[p]];
        if (readyNow && ens[p]) begin
          newW = oldW[p];
          for (int l = 0; l < 4; l++) if (wes[p][l]) newW[8*l +: 8] = dis[p][8*l +: 8];
          expDo[0][p]  = oldW[p];
          expDo[1][p]  = newW;
          expVld[0][p] = 1'b1;
          expVld[1][p] = 1'b1;
        end else begin
          expDo[0][p]  = 32'h0;
          expDo[1][p]  = 32'h0;
          expVld[0][p] = 1'b0;
          expVld[1][p] = 1'b0;
        end
      end
      expColl = readyNow && en0 && en1 && (idx[0] == idx[1]) && ((we0 & we1) != 4'h0);
      if (readyNow) begin
        for (int p = 0; p < 2; p++) begin
          if (ens[p]) begin
            for (int l = 0; l < 4; l++)
              if (wes[p][l]) refMem[idx[p]][8*l +: 8] = dis[p][8*l +: 8];
          end
        end
      end
      if (remBusy > 0) begin
        expBusy = 1'b1;
        remBusy--;
      end else begin
        expBusy = 1'b0;
      end
    end
  endtask

  task automatic compareAll();
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("dut%0d_do0", g), do0_o[g], expDo[g][0]);
      checkOutput($sformatf("dut%0d_do1", g), do1_o[g], expDo[g][1]);
      checkOutput($sformatf("dut%0d_vld0", g), 32'(vld0_o[g]), 32'(expVld[g][0]));
      checkOutput($sformatf("dut%0d_vld1", g), 32'(vld1_o[g]), 32'(expVld[g][1]));
      checkOutput($sformatf("dut%0d_busy", g), 32'(busy_o[g]), 32'(expBusy));
      checkOutput($sformatf("dut%0d_coll", g), 32'(coll_o[g]), 32'(expColl));
    end
  endtask

  task automatic applyStimulus(
    input logic r,
    input logic e0, input logic [3:0] w0, input logic [31:0] ad0, input logic [31:0] d0,
    input logic e1, input logic [3:0] w1, input logic [31:0] ad1, input logic [31:0] d1
  );
    rst = r;
    en0 = e0; we0 = w0; a0 = ad0; di0 = d0;
    en1 = e1; we1 = w1; a1 = ad1; di1 = d1;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Runs until BUSY drops (bounded), optionally attempting a write to word 3 each cycle.
  task automatic waitReady(input logic poke, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      applyStimulus(1'b0, poke, {4{poke}}, 32'hC, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0, 32'h0);
      if (busy_o[0]) n++;
      else done = 1'b1;
    end
    if (!done) checkOutput("busy_timeout", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nBusy;
    logic [31:0] ra0, ra1;

    // Clear sequence after a 3-cycle reset.
    repeat (3) idle(1'b1);
    waitReady(1'b0, nBusy);
    checkOutput("clear_busy_len", 32'(nBusy), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b1, 4'h0, 32'((15 - i) * 4), 32'h0);
      checkOutput("clear_rd0", do0_o[0], 32'h0);
      checkOutput("clear_vld0", 32'(vld0_o[0]), 32'd1);
    end

    // Byte lanes.
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h8, 32'hAABB_CCDD, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h2, 32'h8, 32'h1122_3344, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
    checkOutput("lane_merge", do1_o[0], 32'hAABB_33DD);

    // Read-during-write on port 0, cross-port read on port 1.
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h4, 32'h1234_5678, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h4, 32'hCAFE_F00D, 1'b1, 4'h0, 32'h4, 32'h0);
    checkOutput("rdw_read_first", do0_o[0], 32'h1234_5678);
    checkOutput("rdw_write_first", do0_o[1], 32'hCAFE_F00D);
    checkOutput("cross_rf", do1_o[0], 32'h1234_5678);
    checkOutput("cross_wf", do1_o[1], 32'h1234_5678);

    // Write/write collision on word 2.
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h8, 32'h1111_1111, 1'b1, 4'h3, 32'h8, 32'h2222_2222);
    checkOutput("coll_pulse", 32'(coll_o[0]), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("coll_drop", 32'(coll_o[0]), 32'd0);
    checkOutput("coll_data", do0_o[0], 32'h1111_2222);

    // Output register latency.
    idle(1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("oreg_early_vld", 32'(vld0_o[2]), 32'd0);
    idle(1'b0);
    checkOutput("oreg_vld", 32'(vld0_o[2]), 32'd1);
    checkOutput("oreg_data", do0_o[2], 32'h1111_2222);
    idle(1'b0);
    checkOutput("oreg_off_vld", 32'(vld0_o[2]), 32'd0);
    checkOutput("oreg_off_data", do0_o[2], 32'h0);

    // Reset reasserted mid-clear, writes ignored while busy.
    applyStimulus(1'b0, 1'b1, 4'hF, 32'hC, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(1'b1);
    repeat (8) idle(1'b0);
    idle(1'b1);
    waitReady(1'b1, nBusy);
    checkOutput("restart_busy_len", 32'(nBusy), 32'd16);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'hC, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("busy_write_ignored", do0_o[0], 32'h0);

    // Randomized traffic on a few words with random aliasing upper bits.
    for (int k = 0; k < 400; k++) begin
      ra0 = ($urandom() & 32'hFFFF_FFC3) | (32'($urandom_range(0, 3)) << 2);
      ra1 = ($urandom() & 32'hFFFF_FFC3) | (32'($urandom_range(0, 3)) << 2);
      applyStimulus(1'b0,
                    1'($urandom_range(0, 3) != 0), 4'($urandom()), ra0, $urandom(),
                    1'($urandom_range(0, 3) != 0), 4'($urandom()), ra1, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
